// File: rtl/xgmii_fifo_pkg.sv
// ---------------------------------------------------------------------------
// xgmii_fifo_pkg
//   Definitions shared by the XGMII receive engine and its FIFO-to-AXIS
//   transmit stage:
//     - bit positions inside the 72-bit receive FIFO word
//     - the drain-stage state encoding (3 bits)
//     - the default TLP length limit in 64-bit beats
//     - the tkeep expansion helper (two DW enables -> eight byte enables)
// ---------------------------------------------------------------------------
package xgmii_fifo_pkg;

    // FIFO word layout: [63:0] data, [64] valid TLP word, [65] TLP last,
    // [66] DW0 enable, [67] DW1 enable, [71:68] reserved.
    localparam int unsigned FIFO_W   = 72;
    localparam int unsigned DATA_MSB = 63;
    localparam int unsigned VALID    = 64;
    localparam int unsigned LAST     = 65;
    localparam int unsigned EN_LO    = 66;
    localparam int unsigned EN_HI    = 67;

    // 4 DW header + 1024 DW payload, in 64-bit beats.
    localparam logic [9:0] DEFAULT_MAX_BEATS = 10'd514;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        XFER  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } rx_state_t;

    // Each DW enable covers four byte lanes; DW0 occupies the low lanes.
    function automatic logic [7:0] tkeep_expand(input logic en_hi, input logic en_lo);
        return {{4{en_hi}}, {4{en_lo}}};
    endfunction

endpackage

// File: rtl/xgmii_fifo_axis_slice.sv
// ---------------------------------------------------------------------------
// xgmii_fifo_axis_slice
//   Single-entry registered output slot for the AXIS transmit interface.
//   A new beat may be loaded whenever the slot is free (empty, or its beat is
//   being accepted this cycle), so back-to-back beats flow at one per cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture new_* into the slot this cycle
//   tready            core ready (acceptance = tvalid && tready)
//   new_tdata/tkeep/  beat presented for loading
//   new_tlast/new_dsc
//   tdata/tkeep/tlast/tvalid/dsc   registered slot contents
//   slot_free         slot can take a beat this cycle
// ---------------------------------------------------------------------------
module xgmii_fifo_axis_slice (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        tready,
    input  logic [63:0] new_tdata,
    input  logic [7:0]  new_tkeep,
    input  logic        new_tlast,
    input  logic        new_dsc,
    output logic [63:0] tdata,
    output logic [7:0]  tkeep,
    output logic        tlast,
    output logic        tvalid,
    output logic        dsc,
    output logic        slot_free
);

    assign slot_free = !tvalid || tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
            dsc    <= 1'b0;
        end else if (load) begin
            // A load while the current beat is accepted replaces it directly.
            tdata  <= new_tdata;
            tkeep  <= new_tkeep;
            tlast  <= new_tlast;
            tvalid <= 1'b1;
            dsc    <= new_dsc;
        end else if (tready) begin
            // Beat accepted (or slot already empty): drop the qualifiers so
            // discontinue never lingers without a valid beat.
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            dsc    <= 1'b0;
        end
    end

endmodule

// File: rtl/xgmii_rxfifo_axis_tx.sv
// ---------------------------------------------------------------------------
// xgmii_rxfifo_axis_tx
//   Downstream stage of the XGMII receive engine, on the PCIe user clock.
//   Pops TLP words from the first-word-fall-through receive FIFO, arbitrates
//   for the PCIe AXIS transmit port with a req/ack pair, and replays the TLP
//   one beat per cycle through a registered output slot. Inter-frame gap
//   words are discarded; a gap word inside a TLP or a TLP longer than
//   MAX_BEATS ends the packet with tx_src_dsc on the final beat.
//
// Parameters
//   MAX_BEATS      maximum 64-bit beats per TLP
//   DW_VALID_BIT   FIFO bit marking a valid TLP word
//   LAST_BIT       FIFO bit marking the last word of a TLP
//
// Ports
//   clk                 PCIe user clock
//   sys_rst_n           asynchronous active-low reset
//   fifo_dout/empty     FIFO head word and empty flag
//   fifo_rd_en          pop strobe (combinational)
//   s_axis_tx_req/ack   transmit port request / grant
//   s_axis_tx_*         AXIS transmit beat (tdata/tkeep/tlast/tvalid/tready)
//   tx_src_dsc          source discontinue, qualifies the final beat
//   tlp_count           TLPs forwarded without discontinue
//   drop_count          words discarded
//
// Build option
//   XGMII_RXFIFO_STATS_EN  when defined, tlp_count/drop_count are live 8-bit
//                          wrapping counters; otherwise both read 8'h00.
// ---------------------------------------------------------------------------
module xgmii_rxfifo_axis_tx
    import xgmii_fifo_pkg::*;
#(
    parameter logic [9:0]  MAX_BEATS    = DEFAULT_MAX_BEATS,
    parameter int unsigned DW_VALID_BIT = VALID,
    parameter int unsigned LAST_BIT     = LAST
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [71:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        s_axis_tx_req,
    input  logic        s_axis_tx_ack,
    input  logic        s_axis_tx_tready,
    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    output logic        tx_src_dsc,
    output logic [7:0]  tlp_count,
    output logic [7:0]  drop_count
);

    rx_state_t   state_q, state_d;
    logic        req_q, req_d;
    logic [9:0]  cnt_q, cnt_d, cnt_inc;
    logic        load, discard, slot_free;
    logic        head_valid, head_last;
    logic [63:0] new_tdata;
    logic [7:0]  new_tkeep;
    logic        new_tlast, new_dsc;
    logic        unused_reserved;

    assign head_valid      = fifo_dout[DW_VALID_BIT];
    assign head_last       = fifo_dout[LAST_BIT];
    assign cnt_inc         = cnt_q + 10'd1;
    assign unused_reserved = ^fifo_dout[71:68];

    // Nothing is popped while reset is asserted, even though the IDLE gap
    // discard condition is combinational on the FIFO head.
    assign fifo_rd_en    = (load || discard) && sys_rst_n;
    assign s_axis_tx_req = req_q;

    // ------------------------------------------------------------------
    // Beat formatting for the word at the FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        new_tdata = fifo_dout[DATA_MSB:0];
        new_tkeep = tkeep_expand(fifo_dout[EN_HI], fifo_dout[EN_LO]);
        new_tlast = head_last;
        new_dsc   = 1'b0;
        if (!head_valid) begin
            // Gap word inside a TLP: close the packet with an all-zero,
            // discontinued final beat.
            new_tdata = '0;
            new_tkeep = '1;
            new_tlast = 1'b1;
            new_dsc   = 1'b1;
        end else if (!head_last && (cnt_inc == MAX_BEATS)) begin
            // Overlong TLP: this beat is forced to be the discontinued last.
            new_tlast = 1'b1;
            new_dsc   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, request, beat counter, pop decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        discard = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!head_valid) begin
                        discard = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (s_axis_tx_ack) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (slot_free && !fifo_empty) begin
                    load  = 1'b1;
                    cnt_d = cnt_inc;
                    if (!head_valid || head_last) begin
                        state_d = DONE;
                    end else if (cnt_inc == MAX_BEATS) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The discontinued final beat may still be waiting in the
                // slot; DONE takes care of its acceptance.
                if (!fifo_empty) begin
                    discard = 1'b1;
                    if (head_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Slot free here means the final beat is being accepted now
                // or was already accepted during DRAIN.
                if (slot_free) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    xgmii_fifo_axis_slice u_slice (
        .clk       (clk),
        .rst_n     (sys_rst_n),
        .load      (load),
        .tready    (s_axis_tx_tready),
        .new_tdata (new_tdata),
        .new_tkeep (new_tkeep),
        .new_tlast (new_tlast),
        .new_dsc   (new_dsc),
        .tdata     (s_axis_tx_tdata),
        .tkeep     (s_axis_tx_tkeep),
        .tlast     (s_axis_tx_tlast),
        .tvalid    (s_axis_tx_tvalid),
        .dsc       (tx_src_dsc),
        .slot_free (slot_free)
    );

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef XGMII_RXFIFO_STATS_EN
    logic [7:0] tlp_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tlp_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (s_axis_tx_tvalid && s_axis_tx_tready && s_axis_tx_tlast && !tx_src_dsc) begin
                tlp_cnt_q <= tlp_cnt_q + 8'd1;
            end
            if (discard) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign tlp_count  = tlp_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    assign tlp_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_xgmii_rxfifo_axis_tx.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_xgmii_rxfifo_axis_tx
//   Directed bench for xgmii_rxfifo_axis_tx (MAX_BEATS overridden to 4).
//   Words pushed into a bench FWFT FIFO are parsed at packet level into the
//   beat sequence the transmit port must show; every cycle with tvalid high
//   the slot is compared against the head of that sequence.
// ---------------------------------------------------------------------------
module tb_xgmii_rxfifo_axis_tx;

    localparam int MAXB = 4;
`ifdef XGMII_RXFIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [71:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        s_axis_tx_req;
    logic        s_axis_tx_ack;
    logic        s_axis_tx_tready;
    logic [63:0] s_axis_tx_tdata;
    logic [7:0]  s_axis_tx_tkeep;
    logic        s_axis_tx_tlast;
    logic        s_axis_tx_tvalid;
    logic        tx_src_dsc;
    logic [7:0]  tlp_count;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    xgmii_rxfifo_axis_tx #(.MAX_BEATS(10'd4)) dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .fifo_dout        (fifo_dout),
        .fifo_empty       (fifo_empty),
        .fifo_rd_en       (fifo_rd_en),
        .s_axis_tx_req    (s_axis_tx_req),
        .s_axis_tx_ack    (s_axis_tx_ack),
        .s_axis_tx_tready (s_axis_tx_tready),
        .s_axis_tx_tdata  (s_axis_tx_tdata),
        .s_axis_tx_tkeep  (s_axis_tx_tkeep),
        .s_axis_tx_tlast  (s_axis_tx_tlast),
        .s_axis_tx_tvalid (s_axis_tx_tvalid),
        .tx_src_dsc       (tx_src_dsc),
        .tlp_count        (tlp_count),
        .drop_count       (drop_count)
    );

    // Bench FIFO (first-word fall-through)
    logic [71:0] mem [256];
    int wr_cnt = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr >= wr_cnt);
    assign fifo_dout  = fifo_empty ? 72'h0 : mem[rd_ptr[7:0]];

    // Expected beat sequence
    logic [63:0] exp_data [256];
    logic [7:0]  exp_keep [256];
    logic        exp_last [256];
    logic        exp_dsc  [256];
    logic        exp_rdrop[256];
    int exp_wr = 0;
    int exp_rd = 0;

    // Accepted-beat log
    logic [63:0] acc_data [256];
    logic [7:0]  acc_keep [256];
    logic        acc_last [256];
    logic        acc_dsc  [256];
    int          acc_cyc  [256];
    int acc_n = 0;

    // Packet-level model state
    bit in_tlp = 0;
    bit draining = 0;
    int nbeat = 0;
    int m_tlp = 0;
    int m_drop = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int req_rises = 0;
    int req_cyc = 0;
    int fall_cyc = -1;
    bit req_prev = 0;
    bit req_pend = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [71:0] mk(input logic [3:0] f, input logic [63:0] d);
        return {4'h0, f, d};
    endfunction

    task automatic add_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic s, input logic rdrop);
        exp_data[exp_wr[7:0]]  = d;
        exp_keep[exp_wr[7:0]]  = k;
        exp_last[exp_wr[7:0]]  = l;
        exp_dsc[exp_wr[7:0]]   = s;
        exp_rdrop[exp_wr[7:0]] = rdrop;
        exp_wr++;
    endtask

    // Packet rules applied to one word inside a TLP.
    task automatic tlp_word(input logic [71:0] w);
        logic [7:0] k;
        k = {{4{w[67]}}, {4{w[66]}}};
        if (!w[64]) begin
            add_beat(64'h0, 8'hff, 1'b1, 1'b1, 1'b1);
            in_tlp = 0;
        end else begin
            nbeat++;
            if (w[65]) begin
                add_beat(w[63:0], k, 1'b1, 1'b0, 1'b1);
                in_tlp = 0;
                m_tlp++;
            end else if (nbeat == MAXB) begin
                add_beat(w[63:0], k, 1'b1, 1'b1, 1'b0);
                in_tlp = 0;
                draining = 1;
            end else begin
                add_beat(w[63:0], k, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic push(input logic [71:0] w);
        mem[wr_cnt[7:0]] = w;
        wr_cnt++;
        if (draining) begin
            m_drop++;
            if (w[65]) draining = 0;
        end else if (!in_tlp) begin
            if (!w[64]) begin
                m_drop++;
            end else begin
                in_tlp = 1;
                nbeat = 0;
                tlp_word(w);
            end
        end else begin
            tlp_word(w);
        end
    endtask

    task automatic check_cycle();
        if (req_pend) begin
            chk("req_fall_after_last", 64'(s_axis_tx_req), 64'(0));
            req_pend = 0;
        end
        if (fifo_empty) chk("rd_en_when_empty", 64'(fifo_rd_en), 64'(0));
        if (s_axis_tx_tvalid) begin
            chk("req_with_valid", 64'(s_axis_tx_req), 64'(1));
            if (exp_rd >= exp_wr) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got tdata=0x%0h, required no beat", s_axis_tx_tdata);
            end else begin
                chk("tdata", s_axis_tx_tdata, exp_data[exp_rd[7:0]]);
                chk("tkeep", 64'(s_axis_tx_tkeep), 64'(exp_keep[exp_rd[7:0]]));
                chk("tlast", 64'(s_axis_tx_tlast), 64'(exp_last[exp_rd[7:0]]));
                chk("tx_src_dsc", 64'(tx_src_dsc), 64'(exp_dsc[exp_rd[7:0]]));
                if (s_axis_tx_tready) begin
                    acc_data[acc_n[7:0]] = s_axis_tx_tdata;
                    acc_keep[acc_n[7:0]] = s_axis_tx_tkeep;
                    acc_last[acc_n[7:0]] = s_axis_tx_tlast;
                    acc_dsc[acc_n[7:0]]  = tx_src_dsc;
                    acc_cyc[acc_n[7:0]]  = cyc;
                    acc_n++;
                    if (exp_rdrop[exp_rd[7:0]]) req_pend = 1;
                    exp_rd++;
                end
            end
        end else begin
            chk("dsc_without_valid", 64'(tx_src_dsc), 64'(0));
        end
    endtask

    // One clock: check at the falling edge, then pop / arbitrate after the rise.
    task automatic step();
        logic rd;
        @(negedge clk);
        if (sys_rst_n) check_cycle();
        rd = fifo_rd_en;
        if (s_axis_tx_req && !req_prev) req_rises++;
        if (!s_axis_tx_req && req_prev) fall_cyc = cyc;
        req_prev = s_axis_tx_req;
        @(posedge clk);
        #1;
        if (rd) begin
            rd_ptr++;
            rd_pulses++;
        end
        cyc++;
        if (s_axis_tx_req) begin
            req_cyc++;
            s_axis_tx_ack = (req_cyc >= 2);
        end else begin
            req_cyc = 0;
            s_axis_tx_ack = 1'b0;
        end
    endtask

    function automatic bit is_idle();
        return (rd_ptr == wr_cnt) && (exp_rd == exp_wr) && !s_axis_tx_req && !s_axis_tx_tvalid;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            step();
            n++;
        end
        chk(name, 64'(is_idle()), 64'(1));
        step();
    endtask

    task automatic check_stats();
        chk("tlp_count", 64'(tlp_count), STATS ? 64'(m_tlp) : 64'(0));
        chk("drop_count", 64'(drop_count), STATS ? 64'(m_drop) : 64'(0));
    endtask

    initial begin
        int b;
        int r0;
        int q0;
        int n;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        sys_rst_n = 1'b0;
        s_axis_tx_ack = 1'b0;
        s_axis_tx_tready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_tvalid", 64'(s_axis_tx_tvalid), 64'(0));
        chk("rst_tdata", s_axis_tx_tdata, 64'(0));
        chk("rst_tkeep", 64'(s_axis_tx_tkeep), 64'(0));
        chk("rst_tlast", 64'(s_axis_tx_tlast), 64'(0));
        chk("rst_dsc", 64'(tx_src_dsc), 64'(0));
        chk("rst_req", 64'(s_axis_tx_req), 64'(0));
        chk("rst_counts", 64'({tlp_count, drop_count}), 64'(0));

        // Test 1: three gap words, then a 3-beat TLP
        for (int i = 0; i < 3; i++) push(72'h0);
        #1;
        chk("rst_no_pop", 64'(fifo_rd_en), 64'(0));
        @(posedge clk);
        #3;
        sys_rst_n = 1'b1;
        s_axis_tx_tready = 1'b1;
        b = acc_n; r0 = rd_pulses;
        push(mk(4'b1101, 64'h1111_0000_0000_0001));
        push(mk(4'b1101, 64'h1111_0000_0000_0002));
        push(mk(4'b1111, 64'h1111_0000_0000_0003));
        wait_idle("t1_idle", 60);
        chk("t1_model_drop", 64'(m_drop), 64'(3));
        chk("t1_rd_pulses", 64'(rd_pulses - r0), 64'(6));
        chk("t1_beats", 64'(acc_n - b), 64'(3));
        chk("t1_keep0", 64'(acc_keep[b[7:0]]), 64'hff);
        chk("t1_keep2", 64'(acc_keep[8'(b + 2)]), 64'hff);
        chk("t1_last_pattern", 64'({acc_last[b[7:0]], acc_last[8'(b + 1)], acc_last[8'(b + 2)]}), 64'b001);
        chk("t1_req_fall_delay", 64'(fall_cyc - acc_cyc[8'(b + 2)]), 64'(1));
        chk("t1_drop_count", 64'(drop_count), STATS ? 64'(3) : 64'(0));
        chk("t1_tlp_count", 64'(tlp_count), STATS ? 64'(1) : 64'(0));

        // Test 2: 1-DW end word
        b = acc_n;
        push(mk(4'b1101, 64'h2222_0000_0000_0001));
        push(mk(4'b0111, 64'h2222_0000_0000_0002));
        wait_idle("t2_idle", 40);
        chk("t2_last_keep", 64'(acc_keep[8'(b + 1)]), 64'h0f);
        chk("t2_last_flags", 64'({acc_last[8'(b + 1)], acc_dsc[8'(b + 1)]}), 64'b10);
        check_stats();

        // Test 3: tready toggling 1,0,0,1 across a 4-beat TLP
        b = acc_n; r0 = rd_pulses;
        push(mk(4'b1101, 64'h3333_0000_0000_0001));
        push(mk(4'b1101, 64'h3333_0000_0000_0002));
        push(mk(4'b1101, 64'h3333_0000_0000_0003));
        push(mk(4'b1111, 64'h3333_0000_0000_0004));
        n = 0;
        while (!is_idle() && n < 80) begin
            s_axis_tx_tready = pat[n % 4];
            step();
            n++;
        end
        chk("t3_idle", 64'(is_idle()), 64'(1));
        s_axis_tx_tready = 1'b1;
        step();
        chk("t3_rd_pulses", 64'(rd_pulses - r0), 64'(4));
        chk("t3_beats", 64'(acc_n - b), 64'(4));
        chk("t3_beat3_data", acc_data[8'(b + 3)], 64'h3333_0000_0000_0004);
        check_stats();

        // Test 4: 6-beat TLP against a 4-beat limit
        b = acc_n; q0 = m_drop;
        push(mk(4'b1101, 64'h4444_0000_0000_0001));
        push(mk(4'b1101, 64'h4444_0000_0000_0002));
        push(mk(4'b1101, 64'h4444_0000_0000_0003));
        push(mk(4'b1101, 64'h4444_0000_0000_0004));
        push(mk(4'b1101, 64'h4444_0000_0000_0005));
        push(mk(4'b1111, 64'h4444_0000_0000_0006));
        wait_idle("t4_idle", 60);
        chk("t4_beats", 64'(acc_n - b), 64'(4));
        chk("t4_beat4_flags", 64'({acc_last[8'(b + 3)], acc_dsc[8'(b + 3)]}), 64'b11);
        chk("t4_model_drop", 64'(m_drop - q0), 64'(2));
        chk("t4_tlp_count", 64'(tlp_count), STATS ? 64'(3) : 64'(0));
        check_stats();

        // Test 5: gap word as the second word of a TLP
        b = acc_n; r0 = req_rises;
        push(mk(4'b1101, 64'h5555_0000_0000_0001));
        push(mk(4'b0000, 64'hdead_beef_dead_beef));
        push(mk(4'b1101, 64'h5555_0000_0000_0003));
        push(mk(4'b1111, 64'h5555_0000_0000_0004));
        wait_idle("t5_idle", 60);
        chk("t5_gap_data", acc_data[8'(b + 1)], 64'h0);
        chk("t5_gap_keep", 64'(acc_keep[8'(b + 1)]), 64'hff);
        chk("t5_gap_flags", 64'({acc_last[8'(b + 1)], acc_dsc[8'(b + 1)]}), 64'b11);
        chk("t5_req_rises", 64'(req_rises - r0), 64'(2));
        check_stats();

        // Test 6: asynchronous reset mid-XFER
        s_axis_tx_tready = 1'b0;
        push(mk(4'b1101, 64'h6666_0000_0000_0001));
        push(mk(4'b1101, 64'h6666_0000_0000_0002));
        push(mk(4'b1101, 64'h6666_0000_0000_0003));
        push(mk(4'b1111, 64'h6666_0000_0000_0004));
        n = 0;
        while (!s_axis_tx_tvalid && n < 30) begin
            step();
            n++;
        end
        chk("t6_in_xfer", 64'(s_axis_tx_tvalid), 64'(1));
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 64'(s_axis_tx_tvalid), 64'(0));
        chk("t6_tdata", s_axis_tx_tdata, 64'(0));
        chk("t6_tkeep_tlast_dsc", 64'({s_axis_tx_tkeep, s_axis_tx_tlast, tx_src_dsc}), 64'(0));
        chk("t6_req", 64'(s_axis_tx_req), 64'(0));
        chk("t6_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("t6_counts", 64'({tlp_count, drop_count}), 64'(0));
        @(posedge clk);
        #3;
        chk("t6_rd_en_held", 64'(fifo_rd_en), 64'(0));
        chk("t6_req_held", 64'(s_axis_tx_req), 64'(0));
        rd_ptr = wr_cnt; exp_rd = exp_wr;
        in_tlp = 0; draining = 0; m_tlp = 0; m_drop = 0;
        req_pend = 0; req_prev = 0; req_cyc = 0; s_axis_tx_ack = 1'b0;
        sys_rst_n = 1'b1;
        s_axis_tx_tready = 1'b1;
        b = acc_n;
        push(mk(4'b1111, 64'h7777_0000_0000_0001));
        wait_idle("t6_recover_idle", 40);
        chk("t6_recover_beats", 64'(acc_n - b), 64'(1));
        chk("t6_recover_tlp", 64'(tlp_count), STATS ? 64'(1) : 64'(0));
        check_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound in case a wait loop is ever bypassed.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000ns");
        $fatal(1);
    end

endmodule
